// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - FIFO read-port drainer with skid buffer onto a valid/ready stream
// Optional packet framing (m_last) enabled by defining STREAM_LAST_EN.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef STREAM_LAST_EN
  output logic                  m_last,
`endif
  output logic [15:0]           word_cnt,
  output logic                  err_underflow
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int FW = OW + 1;

  if (SKID_DEPTH < 2 || SKID_DEPTH > 4 || PKT_LEN < 1) begin : g_bad_params
    $error("fifo_rd_streamer: SKID_DEPTH must be 2..4 and PKT_LEN >= 1");
  end

  logic [FIFO_WIDTH-1:0] skid [SKID_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [OW-1:0]         occ;
  logic                  inflight;
  logic                  pop;
  logic [FW-1:0]         fill;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = skid[rd_ptr];

  // Occupancy after this cycle, counting the word already in flight from the FIFO.
  // pop implies occ != 0, so this never goes negative.
  assign fill       = {1'b0, occ} + FW'(inflight) - FW'(pop);
  assign fifo_rd_en = !rst && !fifo_empty && (fill < FW'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      occ           <= '0;
      inflight      <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      word_cnt      <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) skid[i] <= '0;
    end else begin
      inflight <= fifo_rd_en && !fifo_empty;
      occ      <= fill[OW-1:0];
      if (inflight) begin
        skid[wr_ptr] <= fifo_data_out;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        word_cnt <= word_cnt + 16'd1;
      end
      // The stale word is still captured; the flag points at a FIFO flag bug.
      if (inflight && fifo_underflow) err_underflow <= 1'b1;
    end
  end

`ifdef STREAM_LAST_EN
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  logic [CW-1:0] pkt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      pkt_cnt <= (pkt_cnt == CW'(PKT_LEN - 1)) ? '0 : pkt_cnt + 1'b1;
    end
  end

  assign m_last = m_valid && (pkt_cnt == CW'(PKT_LEN - 1));
`endif

endmodule
